uart_recv: RTL

- Receive-side counterpart of the board's ADC-to-PC serial link.
- Deserialises 8N1 UART characters from a serial line and parses the fixed 7-character voltage line format "D.DDD<CR><LF>" back into four BCD digits.
- Sits in the FPGA fabric behind the board's serial input pin. Used to loop back and self-check transmitted ADC readings, and to accept readings from a PC.

---
 rtl/uart_recv_if.sv | 28 ++
 rtl/uart_recv.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_recv_if.sv
// uart_recv_if: serial input and parsed-value outputs of uart_recv (err_count present with UART_RECV_ERR_CNT_EN)
interface uart_recv_if;
  logic       serial_data_in;
  logic [3:0] thousands;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       value_valid;
  logic       frame_error;
  logic       format_error;
`ifdef UART_RECV_ERR_CNT_EN
  logic [7:0] err_count;
`endif
  modport master (
    output serial_data_in,
    input  thousands, hundreds, tens, ones, value_valid, frame_error, format_error
`ifdef UART_RECV_ERR_CNT_EN
    , input err_count
`endif
  );
  modport slave (
    input  serial_data_in,
    output thousands, hundreds, tens, ones, value_valid, frame_error, format_error
`ifdef UART_RECV_ERR_CNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver parsing "D.DDD<CR><LF>" lines into BCD digits; UART_RECV_ERR_CNT_EN adds a saturating err_count
module uart_recv #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input logic        clk,
  input logic        reset_n,
  uart_recv_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;
  typedef enum logic [2:0] {P_D1000, P_DP, P_D100, P_D10, P_D1, P_CR, P_LF, P_SYNC} parse_state_t;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd;
  bit_state_t             state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [2:0]             idx, idx_d;
  logic [7:0]             sh, sh_d;
  logic                   char_strobe, frame_err;
  parse_state_t           pstate, pstate_d;
  logic [3:0]             th_s, hu_s, te_s, on_s;
  logic                   is_digit, value_ok, fmt_err;
  assign rxd      = sync_q[SYNC_STAGES-1];
  assign is_digit = sh[7:4] == 4'h3 && sh[3:0] <= 4'd9;
  // synchroniser and bit-level receive registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '1;
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.serial_data_in};
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      sh     <= sh_d;
    end
  end
  // bit FSM: mid-bit sampling; leaves STOP at mid-stop so back-to-back frames are caught
  always_comb begin
    state_d     = state;
    cnt_d       = cnt + 1'b1;
    idx_d       = idx;
    sh_d        = sh;
    char_strobe = 1'b0;
    frame_err   = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rxd) state_d = START;
      end
      START: if (cnt == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxd ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_d = '0;
        sh_d  = {rxd, sh[7:1]};
        idx_d = idx + 1'b1;
        if (idx == 3'd7) state_d = STOP;
      end
      STOP: if (cnt == LAST) begin
        cnt_d       = '0;
        state_d     = IDLE;
        char_strobe = rxd;
        frame_err   = !rxd;
      end
    endcase
  end
  // line parser: a frame error or any bad character drops into P_SYNC until the next LF
  always_comb begin
    pstate_d = pstate;
    value_ok = 1'b0;
    fmt_err  = 1'b0;
    if (frame_err) pstate_d = P_SYNC;
    else if (char_strobe) begin
      case (pstate)
        P_D1000: pstate_d = is_digit ? P_DP : P_SYNC;
        P_DP:    pstate_d = sh == 8'h2E ? P_D100 : P_SYNC;
        P_D100:  pstate_d = is_digit ? P_D10 : P_SYNC;
        P_D10:   pstate_d = is_digit ? P_D1 : P_SYNC;
        P_D1:    pstate_d = is_digit ? P_CR : P_SYNC;
        P_CR:    pstate_d = sh == 8'h0D ? P_LF : P_SYNC;
        P_LF:    pstate_d = sh == 8'h0A ? P_D1000 : P_SYNC;
        P_SYNC:  pstate_d = sh == 8'h0A ? P_D1000 : P_SYNC;
      endcase
      fmt_err  = pstate != P_SYNC && pstate_d == P_SYNC;
      value_ok = pstate == P_LF && pstate_d == P_D1000;
    end
  end
  // parser state, digit shadows and registered outputs; digits only move on a complete line
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pstate           <= P_D1000;
      th_s             <= '0;
      hu_s             <= '0;
      te_s             <= '0;
      on_s             <= '0;
      bus.thousands    <= '0;
      bus.hundreds     <= '0;
      bus.tens         <= '0;
      bus.ones         <= '0;
      bus.value_valid  <= 1'b0;
      bus.frame_error  <= 1'b0;
      bus.format_error <= 1'b0;
    end else begin
      pstate           <= pstate_d;
      bus.value_valid  <= value_ok;
      bus.frame_error  <= frame_err;
      bus.format_error <= fmt_err;
      if (char_strobe && is_digit) begin
        if (pstate == P_D1000) th_s <= sh[3:0];
        if (pstate == P_D100) hu_s <= sh[3:0];
        if (pstate == P_D10) te_s <= sh[3:0];
        if (pstate == P_D1) on_s <= sh[3:0];
      end
      if (value_ok) begin
        bus.thousands <= th_s;
        bus.hundreds  <= hu_s;
        bus.tens      <= te_s;
        bus.ones      <= on_s;
      end
    end
  end
`ifdef UART_RECV_ERR_CNT_EN
  // saturating count of frame and format errors, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset_n) bus.err_count <= '0;
    else if ((frame_err || fmt_err) && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 1'b1;
  end
`endif
endmodule
